// File: rtl/rv32_mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between an instruction-fetch port and a
// data load/store port, with one outstanding transaction, response timeout and data range check.
module rv32_mem_arbiter #(
  parameter int unsigned AW               = 32,
  parameter int unsigned DW               = 32,
  parameter int unsigned DATA_MEMORY_BASE = 32'h0000_0400,
  parameter int unsigned DATA_MEMORY_SIZE = 32'd1024,
  parameter int unsigned TIMEOUT          = 32'd15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  output logic            i_err,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            d_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  localparam int unsigned SW = DW / 8;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_GNT = 2'd1;
  localparam logic [1:0] ST_WAIT_RSP = 2'd2;
  localparam logic [1:0] ST_ERR_RSP  = 2'd3;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [AW:0] BASE_X = (AW+1)'(DATA_MEMORY_BASE);
  localparam logic [AW:0] SIZE_X = (AW+1)'(DATA_MEMORY_SIZE);
  localparam logic [8:0]  TMO_X  = 9'(TIMEOUT);

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [SW-1:0] mem_wstrb_q, mem_wstrb_d;
  logic          i_rvalid_q, i_rvalid_d;
  logic          i_err_q, i_err_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic          d_rvalid_q, d_rvalid_d;
  logic          d_err_q, d_err_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic          arb_en_s;
  logic          win_i_s;
  logic          win_d_s;
  logic [AW:0]   d_off_s;
  logic          d_in_range_s;
  logic          tmo_s;

  // Offset computed one bit wider so addresses below the base cannot wrap into range.
  assign d_off_s      = {1'b0, d_addr} - BASE_X;
  assign d_in_range_s = ({1'b0, d_addr} >= BASE_X) && (d_off_s < SIZE_X);

  // ERR_RSP only emits a registered response, so it may arbitrate like IDLE.
  assign arb_en_s = !reset && ((state_q == ST_IDLE) || (state_q == ST_ERR_RSP));
  assign win_d_s  = arb_en_s && d_req && (!i_req || (last_q == OWN_I));
  assign win_i_s  = arb_en_s && i_req && !win_d_s;
  assign tmo_s    = ({1'b0, cnt_q} + 9'd1) >= TMO_X;

  // Next-state, command capture and response generation.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    i_rvalid_d  = 1'b0;
    i_err_d     = 1'b0;
    i_rdata_d   = {DW{1'b0}};
    d_rvalid_d  = 1'b0;
    d_err_d     = 1'b0;
    d_rdata_d   = {DW{1'b0}};
    case (state_q)
      ST_IDLE, ST_ERR_RSP: begin
        if (win_d_s) begin
          owner_d     = OWN_D;
          last_d      = OWN_D;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_wstrb_d = d_wstrb;
          if (d_in_range_s) begin
            state_d   = ST_WAIT_GNT;
            mem_req_d = 1'b1;
          end else begin
            state_d    = ST_ERR_RSP;
            d_rvalid_d = 1'b1;
            d_err_d    = 1'b1;
          end
        end else if (win_i_s) begin
          owner_d     = OWN_I;
          last_d      = OWN_I;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = {DW{1'b0}};
          mem_wstrb_d = {SW{1'b0}};
          state_d     = ST_WAIT_GNT;
          mem_req_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_GNT: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          cnt_d     = 8'd0;
          state_d   = ST_WAIT_RSP;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      ST_WAIT_RSP: begin
        if (mem_rvalid) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_D) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = mem_rdata;
          end else begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = mem_rdata;
          end
        end else if (tmo_s) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_D) begin
            d_rvalid_d = 1'b1;
            d_err_d    = 1'b1;
          end else begin
            i_rvalid_d = 1'b1;
            i_err_d    = 1'b1;
          end
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_I;
      last_q      <= OWN_I;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
      mem_wstrb_q <= {SW{1'b0}};
      i_rvalid_q  <= 1'b0;
      i_err_q     <= 1'b0;
      i_rdata_q   <= {DW{1'b0}};
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= {DW{1'b0}};
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      i_rvalid_q  <= i_rvalid_d;
      i_err_q     <= i_err_d;
      i_rdata_q   <= i_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign i_gnt     = win_i_s;
  assign d_gnt     = win_d_s;
  assign i_rvalid  = i_rvalid_q;
  assign i_err     = i_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
